// File: rtl/cs_rr_if.sv
// cs_rr_if: request/enable inputs and chip-select outputs of the round-robin select arbiter
interface cs_rr_if;
   logic       en;
   logic [7:0] req;
   logic [7:0] cs_n;
   logic [2:0] gnt_idx;
   logic       busy;
   logic       timeout;
   modport master(output en, req, input cs_n, gnt_idx, busy, timeout);
   modport slave(input en, req, output cs_n, gnt_idx, busy, timeout);
endinterface

// File: rtl/cs_rr_arbiter.sv
// cs_rr_arbiter: round-robin owner of an 8-way active-low chip-select with hold timeout and turnaround gap
module cs_rr_arbiter #(
   parameter int MAX_HOLD   = 16,
   parameter int GAP_CYCLES = 1
) (
   input logic    clk,
   input logic    rst_n,
   cs_rr_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
   state_t     r_state, w_next;
   logic [2:0] r_ptr, r_idx, w_win, w_idx_nx, w_ptr_nx;
   logic [7:0] r_cs_n, r_hold, w_cs_n_nx, w_hold_nx;
   logic [3:0] r_gap, w_gap_nx;
   logic       r_to, w_to_nx, w_take, w_drop, w_expire, w_release, w_gap_done;
   // Descending scan so the last hit is the one closest to ptr
   always_comb begin
      w_win = r_ptr;
      for (int k = 7; k >= 0; k--)
         if (bus.req[r_ptr + 3'(k)]) w_win = r_ptr + 3'(k);
   end
   assign w_drop     = !bus.req[r_idx];
   assign w_expire   = (MAX_HOLD != 0) && (r_hold == 8'(MAX_HOLD));
   assign w_gap_done = r_gap == 4'(GAP_CYCLES - 1);
   assign w_take     = (r_state == IDLE) && bus.en && (|bus.req);
   assign w_release  = (r_state == BUSY) && (w_drop || w_expire);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_cs_n  <= 8'hFF;
         r_idx   <= 3'd0;
         r_ptr   <= 3'd0;
         r_hold  <= 8'd0;
         r_gap   <= 4'd0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cs_n  <= w_cs_n_nx;
         r_idx   <= w_idx_nx;
         r_ptr   <= w_ptr_nx;
         r_hold  <= w_hold_nx;
         r_gap   <= w_gap_nx;
         r_to    <= w_to_nx;
      end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_take) w_next = BUSY;
         BUSY:    if (w_release) w_next = (GAP_CYCLES > 0) ? GAP : IDLE;
         GAP:     if (w_gap_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   // A drop on the same edge the hold limit is reached is a normal release
   always_comb begin
      w_cs_n_nx = w_take ? ~(8'd1 << w_win) : w_release ? 8'hFF : r_cs_n;
      w_idx_nx  = w_take ? w_win : r_idx;
      w_ptr_nx  = w_take ? w_win + 3'd1 : r_ptr;
      w_hold_nx = w_take ? 8'd1 : ((r_state == BUSY) && (r_hold != 8'hFF)) ? r_hold + 8'd1 : r_hold;
      w_gap_nx  = (r_state == GAP) ? r_gap + 4'd1 : 4'd0;
      w_to_nx   = w_release && !w_drop;
   end
   assign bus.cs_n    = r_cs_n;
   assign bus.gnt_idx = r_idx;
   assign bus.busy    = ~&r_cs_n;
   assign bus.timeout = r_to;
endmodule

// File: doc/cs_rr_arbiter.md
Name: cs_rr_arbiter

Overview:
- Round-robin scheduler that shares one 3-to-8 active-low chip-select decoder among 8 requesters.
- Each cycle it either holds the current owner's select line low or parks all selects high.
- Sits between bus masters' request lines and the decoder-driven peripheral bank. It sequences select index, enable and bus-turnaround gaps.
- Adds per-grant hold timeout and a global enable gate, equivalent to the G1/G2 enables of the 74138.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may stay active. 0 means unlimited. Legal range 0..255.
- GAP_CYCLES, 1, dead cycles with all selects high after each release. Legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable. While low, no new grant is issued; an active grant runs to completion.
- req  input  8  request vector; bit i = requester i. Level-sensitive; held high for the whole transaction.
- cs_n  output  8  registered active-low one-hot select. 8'hFF when nothing is granted.
- gnt_idx  output  3  registered index of the current or last winner.
- busy  output  1  high while any cs_n bit is low.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async assert, synchronous to clk on release) forces the following:
  - state = IDLE.
  - cs_n = 8'hFF, gnt_idx = 0, busy = 0, timeout = 0.
  - Priority pointer ptr = 0; hold and gap counters = 0.
- States: IDLE, BUSY, GAP.
- IDLE:
  - Applies when en = 1 and req != 0.
  - Winner is the first set bit searching ptr, ptr+1, … 7, 0, … ptr-1 (mod-8 wrap).
  - At the clock edge: cs_n[winner] goes low, gnt_idx = winner, busy = 1, ptr = winner+1 mod 8 (7 wraps to 0), hold counter = 1, next state BUSY.
  - Latency: req sampled high at edge k gives cs_n low after edge k, i.e. one cycle.
  - If en = 0 or req = 0, remain in IDLE with outputs unchanged.
- BUSY:
  - Release when req[gnt_idx] = 0, or when MAX_HOLD != 0 and hold counter == MAX_HOLD.
  - At the release edge: cs_n = 8'hFF, busy = 0. Next state is GAP if GAP_CYCLES > 0, otherwise IDLE.
  - If the release is a timeout, timeout = 1 for exactly the following cycle.
  - If req drops on the same cycle the counter hits MAX_HOLD, it counts as a normal release: timeout stays 0.
  - Otherwise the hold counter increments; it saturates at 255 when MAX_HOLD = 0.
  - Other req bits changing during BUSY have no effect.
  - en going low during BUSY has no effect.
- GAP:
  - The gap counter counts GAP_CYCLES cycles with cs_n = 8'hFF, then returns to IDLE.
  - New arbitration happens in IDLE, so the minimum spacing between grants is GAP_CYCLES + 1 dead cycles.
  - Exception: with GAP_CYCLES = 0 the spacing is 1 dead cycle.
- A timed-out requester that still holds req is skipped once, because ptr has advanced past it. It may win again on its next turn.
- cs_n always has at most one bit low. gnt_idx keeps its value after release.
- Reset asserted mid-BUSY: cs_n returns to 8'hFF immediately (asynchronously) and ptr returns to 0.

Test Plan:
- Reset then single request: rst_n low, then high; req = 8'b0000_0100 held → cs_n = 8'hFB one cycle later, gnt_idx = 2, busy = 1, ptr = 3. Drop req → next cycle cs_n = 8'hFF, then 1 GAP cycle, then IDLE.
- Round-robin fairness: req = 8'hFF held, each master drops req after 2 cycles then re-raises → grant order 0,1,2,…,7,0. cs_n cycles FE, FD, FB, F7, EF, DF, BF, 7F.
- Wrap-around: ptr = 6, req = 8'b0000_0011 → grant 0 (cs_n = FE), then 1. Never skip to 7 or 6.
- Timeout (MAX_HOLD = 4): req[5] held high → cs_n = 8'hDF for exactly 4 cycles, then 8'hFF with timeout = 1 for one cycle. With req[3] also high, next grant is 3, then 5.
- Enable gating: en = 0 with req = 8'h10 → cs_n stays 8'hFF. Raise en → cs_n = 8'hEF next cycle. Drop en mid-grant → cs_n stays 8'hEF until req[4] drops.
- Async reset mid-grant: during BUSY with cs_n = 8'hF7, pulse rst_n low between clock edges → cs_n = 8'hFF, busy = 0 with no clock edge. After release, req = 8'hFF gives grant 0.
